pu_msp430_per_arbiter: RTL and testbench

Two-master arbiter that shares the 16-bit peripheral register bus (per_addr/per_din/per_en/per_we/per_dout) between two requesters, e.g. the CPU frontend and a debug/DMA engine. It grants one single-cycle peripheral access at a time, captures read data from per_dout, and returns it with a one-cycle acknowledge. It sits between the requesters and the peripheral bus, so slave peripherals such as the 16-bit control-register templates need no changes.

---
 rtl/pu_msp430_per_arb_pkg.sv | 16 +
 rtl/pu_msp430_rr_arbiter2.sv | 26 ++
 rtl/pu_msp430_per_arbiter.sv | 112 +++++++++++
 tb/tb_pu_msp430_per_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_msp430_per_arb_pkg.sv
// Shared types for the two-master peripheral bus arbiter.
// State encoding, arbitration modes and the master index type.
package pu_msp430_per_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        ACK  = 2'd2
    } arb_state_e;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef logic midx_t;

endpackage

// File: rtl/pu_msp430_rr_arbiter2.sv
// Two-way winner select: round-robin on last grant or fixed priority.
// Masked requesters never win, so a just-served master yields.
module pu_msp430_rr_arbiter2
    import pu_msp430_per_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  midx_t      last_gnt_i,
    input  logic       mode_i,
    input  logic [1:0] excl_i,
    output logic       valid_o,
    output midx_t      winner_o
);

    logic [1:0] eff;

    assign eff     = req_i & ~excl_i;
    assign valid_o = |eff;

    always_comb begin
        winner_o = eff[1];
        if (&eff) begin
            winner_o = mode_i ? 1'b0 : ~last_gnt_i;
        end
    end

endmodule

// File: rtl/pu_msp430_per_arbiter.sv
// Shares the peripheral register bus between two masters,
// one single-cycle access at a time with a registered ack.
module pu_msp430_per_arbiter
    import pu_msp430_per_arb_pkg::*;
#(
    parameter int ARB_MODE = ARB_RR
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        m0_req,
    input  logic [13:0] m0_addr,
    input  logic [15:0] m0_din,
    input  logic [1:0]  m0_we,
    output logic        m0_ack,
    output logic [15:0] m0_dout,
    input  logic        m1_req,
    input  logic [13:0] m1_addr,
    input  logic [15:0] m1_din,
    input  logic [1:0]  m1_we,
    output logic        m1_ack,
    output logic [15:0] m1_dout,
    output logic        per_en,
    output logic [13:0] per_addr,
    output logic [15:0] per_din,
    output logic [1:0]  per_we,
    input  logic [15:0] per_dout
);

    arb_state_e  state_q, state_d;
    midx_t       gnt_q, gnt_d;
    midx_t       last_gnt_q, last_gnt_d;
    logic [15:0] rdata_q, rdata_d;

    logic        arb_valid;
    midx_t       arb_winner;
    logic [1:0]  excl;
    logic [13:0] sel_addr;
    logic [15:0] sel_din;
    logic [1:0]  sel_we;

    // The master being acked may not win again in its own ACK cycle.
    assign excl = (state_q != ACK) ? 2'b00 :
                  (gnt_q ? 2'b10 : 2'b01);

    pu_msp430_rr_arbiter2 u_sel (
        .req_i      ({m1_req, m0_req}),
        .last_gnt_i (last_gnt_q),
        .mode_i     (ARB_MODE == ARB_FIXED),
        .excl_i     (excl),
        .valid_o    (arb_valid),
        .winner_o   (arb_winner)
    );

    assign sel_addr = gnt_q ? m1_addr : m0_addr;
    assign sel_din  = gnt_q ? m1_din  : m0_din;
    assign sel_we   = gnt_q ? m1_we   : m0_we;

    assign per_en   = (state_q == BUS);
    assign per_addr = per_en ? sel_addr : 14'h0000;
    assign per_din  = per_en ? sel_din  : 16'h0000;
    assign per_we   = per_en ? sel_we   : 2'b00;

    assign m0_ack  = (state_q == ACK) && !gnt_q;
    assign m1_ack  = (state_q == ACK) &&  gnt_q;
    assign m0_dout = m0_ack ? rdata_q : 16'h0000;
    assign m1_dout = m1_ack ? rdata_q : 16'h0000;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        rdata_d    = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d      = arb_winner;
                    last_gnt_d = arb_winner;
                    state_d    = BUS;
                end
            end
            BUS: begin
                rdata_d = (sel_we == 2'b00) ? per_dout : 16'h0000;
                state_d = ACK;
            end
            ACK: begin
                if (arb_valid) begin
                    gnt_d      = arb_winner;
                    last_gnt_d = arb_winner;
                    state_d    = BUS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            rdata_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_pu_msp430_per_arbiter.sv
// Bench for the peripheral arbiter: a round-robin and a
// fixed-priority instance share one set of master inputs.
module tb_pu_msp430_per_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req, m1_req;
    logic [13:0] m0_addr, m1_addr;
    logic [15:0] m0_din, m1_din;
    logic [1:0]  m0_we, m1_we;

    logic        r_m0_ack, r_m1_ack, r_per_en;
    logic [15:0] r_m0_dout, r_m1_dout, r_per_din, r_per_dout;
    logic [13:0] r_per_addr;
    logic [1:0]  r_per_we;

    logic        f_m0_ack, f_m1_ack, f_per_en;
    logic [15:0] f_m0_dout, f_m1_dout, f_per_din;
    logic [15:0] f_per_dout;
    logic [13:0] f_per_addr;
    logic [1:0]  f_per_we;

    logic [15:0] reg_c9 = 16'h0000;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    typedef struct packed {
        logic        m;
        logic [15:0] d;
    } exp_t;

    exp_t sbq[$];

    pu_msp430_per_arbiter #(.ARB_MODE(0)) dut_rr (
        .mclk(clk), .puc_rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_we(m0_we), .m0_ack(r_m0_ack), .m0_dout(r_m0_dout),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_we(m1_we), .m1_ack(r_m1_ack), .m1_dout(r_m1_dout),
        .per_en(r_per_en), .per_addr(r_per_addr),
        .per_din(r_per_din), .per_we(r_per_we),
        .per_dout(r_per_dout)
    );

    pu_msp430_per_arbiter #(.ARB_MODE(1)) dut_fx (
        .mclk(clk), .puc_rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_we(m0_we), .m0_ack(f_m0_ack), .m0_dout(f_m0_dout),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_we(m1_we), .m1_ack(f_m1_ack), .m1_dout(f_m1_dout),
        .per_en(f_per_en), .per_addr(f_per_addr),
        .per_din(f_per_din), .per_we(f_per_we),
        .per_dout(f_per_dout)
    );

    // Peripheral model: one register at 0x00C9, else reads return the address.
    assign r_per_dout = !r_per_en ? 16'h0000 :
                        (r_per_addr == 14'h00C9) ? reg_c9 :
                        {2'b00, r_per_addr};
    assign f_per_dout = 16'h0000;

    always @(posedge clk) begin
        if (r_per_en && r_per_addr == 14'h00C9) begin
            if (r_per_we[0]) reg_c9[7:0]  <= r_per_din[7:0];
            if (r_per_we[1]) reg_c9[15:8] <= r_per_din[15:8];
        end
    end

    task automatic test_reset();
        m0_req = 1'b1; m1_req = 1'b1;
        m0_addr = 14'h0001; m1_addr = 14'h0002;
        m0_din = 16'h0; m1_din = 16'h0;
        m0_we = 2'b00; m1_we = 2'b00;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_cnt++;
            if ({r_per_en, r_m0_ack, r_m1_ack, r_m0_dout, r_m1_dout,
                 r_per_addr, r_per_din, r_per_we} !== '0)
                $display("FAIL rst_outs: per_en=%b acks=%b%b addr=%h",
                         r_per_en, r_m0_ack, r_m1_ack, r_per_addr);
            else pass_cnt++;
        end
        rst = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (r_per_en !== 1'b1 || r_per_addr !== 14'h0001)
            $display("FAIL rst_first_grant: en=%b addr=%h want 1/0001",
                     r_per_en, r_per_addr);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (r_m0_ack !== 1'b1 || r_m1_ack !== 1'b0)
            $display("FAIL rst_first_ack: acks=%b%b want m0",
                     r_m1_ack, r_m0_ack);
        else pass_cnt++;
        m0_req = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (r_per_en !== 1'b1 || r_per_addr !== 14'h0002)
            $display("FAIL rst_loser_bus: en=%b addr=%h want 1/0002",
                     r_per_en, r_per_addr);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (r_m1_ack !== 1'b1 || r_m0_ack !== 1'b0)
            $display("FAIL rst_loser_ack: acks=%b%b want m1",
                     r_m1_ack, r_m0_ack);
        else pass_cnt++;
        m1_req = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (r_per_en !== 1'b0 || r_m0_ack !== 1'b0 || r_m1_ack !== 1'b0)
            $display("FAIL rst_idle: en=%b acks=%b%b want 0",
                     r_per_en, r_m1_ack, r_m0_ack);
        else pass_cnt++;
    endtask

    task automatic test_rr_contention();
        int a0 = 0, a1 = 0, last_en = -1, cyc = 0;
        exp_t e;
        sbq.delete();
        for (int i = 0; i < 6; i++) begin
            e.m = i[0];
            e.d = i[0] ? 16'h0020 : 16'h0010;
            sbq.push_back(e);
        end
        m0_addr = 14'h0010; m1_addr = 14'h0020;
        m0_we = 2'b00; m1_we = 2'b00;
        m0_req = 1'b1; m1_req = 1'b1;
        while ((a0 + a1) < 6 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (r_per_en) begin
                if (last_en >= 0) begin
                    chk_cnt++;
                    if (cyc - last_en != 2)
                        $display("FAIL rr_en_gap: got %0d want 2",
                                 cyc - last_en);
                    else pass_cnt++;
                end
                last_en = cyc;
            end
            if (r_m0_ack || r_m1_ack) begin
                chk_cnt++;
                if (sbq.size() == 0) begin
                    $display("FAIL rr_extra_ack: acks=%b%b",
                             r_m1_ack, r_m0_ack);
                end else begin
                    e = sbq.pop_front();
                    if (r_m1_ack !== e.m || r_m0_ack !== !e.m ||
                        (e.m ? r_m1_dout : r_m0_dout) !== e.d)
                        $display("FAIL rr_order: acks=%b%b d0=%h d1=%h want m%0d %h",
                                 r_m1_ack, r_m0_ack, r_m0_dout,
                                 r_m1_dout, e.m, e.d);
                    else pass_cnt++;
                end
                if (r_m0_ack) begin a0++; if (a0 == 3) m0_req = 1'b0; end
                if (r_m1_ack) begin a1++; if (a1 == 3) m1_req = 1'b0; end
            end
        end
        chk_cnt++;
        if (a0 + a1 != 6)
            $display("FAIL rr_timeout: acks %0d want 6", a0 + a1);
        else pass_cnt++;
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_read();
        exp_t e;
        for (int op = 0; op < 2; op++) begin
            int cyc = 0, en_seen = 0;
            bit done = 1'b0;
            m0_addr = 14'h00C9;
            m0_din  = 16'hA5A5;
            m0_we   = (op == 0) ? 2'b11 : 2'b00;
            e.m = 1'b0;
            e.d = (op == 0) ? 16'h0000 : 16'hA5A5;
            sbq.push_back(e);
            m0_req = 1'b1;
            while (!done && cyc < 10) begin
                @(negedge clk);
                cyc++;
                if (r_per_en) begin
                    en_seen++;
                    chk_cnt++;
                    if (r_per_addr !== 14'h00C9 || r_per_we !== m0_we ||
                        r_per_din !== 16'hA5A5)
                        $display("FAIL wr_bus: addr=%h we=%b din=%h want 00c9/%b/a5a5",
                                 r_per_addr, r_per_we, r_per_din, m0_we);
                    else pass_cnt++;
                end
                if (r_m0_ack) begin
                    e = sbq.pop_front();
                    done = 1'b1;
                    m0_req = 1'b0;
                    chk_cnt++;
                    if (r_m0_dout !== e.d || cyc != 2 || en_seen != 1)
                        $display("FAIL wr_ack: dout=%h cyc=%0d en=%0d want %h/2/1",
                                 r_m0_dout, cyc, en_seen, e.d);
                    else pass_cnt++;
                end
            end
            chk_cnt++;
            if (!done)
                $display("FAIL wr_timeout: op %0d got no ack", op);
            else pass_cnt++;
            @(negedge clk);
            chk_cnt++;
            if (r_m0_dout !== 16'h0000 || r_m0_ack !== 1'b0)
                $display("FAIL wr_dout_clear: dout=%h ack=%b want 0",
                         r_m0_dout, r_m0_ack);
            else pass_cnt++;
        end
    endtask

    task automatic test_stream();
        int n = 0, cyc = 0, last = -1;
        exp_t e;
        logic [13:0] addrs [3];
        addrs[0] = 14'h0011; addrs[1] = 14'h0022; addrs[2] = 14'h0033;
        sbq.delete();
        for (int i = 0; i < 3; i++) begin
            e.m = 1'b1;
            e.d = {2'b00, addrs[i]};
            sbq.push_back(e);
        end
        m1_we = 2'b00; m1_addr = addrs[0];
        m0_req = 1'b0; m1_req = 1'b1;
        while (n < 3 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (r_m0_ack) begin
                chk_cnt++;
                $display("FAIL st_m0_ack: got 1 want 0");
            end
            if (r_m1_ack) begin
                e = sbq.pop_front();
                chk_cnt++;
                if (r_m1_dout !== e.d)
                    $display("FAIL st_data: got %h want %h", r_m1_dout, e.d);
                else pass_cnt++;
                if (last >= 0) begin
                    chk_cnt++;
                    if (cyc - last != 3)
                        $display("FAIL st_gap: got %0d want 3", cyc - last);
                    else pass_cnt++;
                end
                last = cyc;
                n++;
                if (n < 3) m1_addr = addrs[n];
                else m1_req = 1'b0;
            end
        end
        chk_cnt++;
        if (n != 3)
            $display("FAIL st_timeout: acks %0d want 3", n);
        else pass_cnt++;
        m1_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fixed();
        int n = 0, cyc = 0, last_en = -1, m0n = 0;
        exp_t e;
        sbq.delete();
        e.d = 16'h0000;
        e.m = 1'b0; sbq.push_back(e);
        e.m = 1'b1; sbq.push_back(e);
        e.m = 1'b0; sbq.push_back(e);
        m0_addr = 14'h0040; m1_addr = 14'h0050;
        m0_we = 2'b00; m1_we = 2'b00;
        m0_req = 1'b1; m1_req = 1'b1;
        while (n < 3 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (f_per_en) begin
                if (last_en >= 0) begin
                    chk_cnt++;
                    if (cyc - last_en != 2)
                        $display("FAIL fx_en_gap: got %0d want 2",
                                 cyc - last_en);
                    else pass_cnt++;
                end
                last_en = cyc;
            end
            if (f_m0_ack || f_m1_ack) begin
                e = sbq.pop_front();
                chk_cnt++;
                if (f_m1_ack !== e.m || f_m0_ack !== !e.m)
                    $display("FAIL fx_order: acks=%b%b want m%0d",
                             f_m1_ack, f_m0_ack, e.m);
                else pass_cnt++;
                n++;
                if (f_m1_ack) m1_req = 1'b0;
                if (f_m0_ack) begin
                    m0n++;
                    if (m0n == 2) m0_req = 1'b0;
                end
            end
        end
        chk_cnt++;
        if (n != 3)
            $display("FAIL fx_timeout: acks %0d want 3", n);
        else pass_cnt++;
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) @(negedge clk);
        // Last grant was m0: fixed keeps m0, round-robin picks m1.
        m0_req = 1'b1; m1_req = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (f_per_en !== 1'b1 || f_per_addr !== 14'h0040)
            $display("FAIL fx_tie_m0: en=%b addr=%h want 1/0040",
                     f_per_en, f_per_addr);
        else pass_cnt++;
        chk_cnt++;
        if (r_per_en !== 1'b1 || r_per_addr !== 14'h0050)
            $display("FAIL rr_tie_m1: en=%b addr=%h want 1/0050",
                     r_per_en, r_per_addr);
        else pass_cnt++;
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (f_m0_ack !== 1'b1 || r_m1_ack !== 1'b1)
            $display("FAIL tie_acks: fx_m0=%b rr_m1=%b want 1/1",
                     f_m0_ack, r_m1_ack);
        else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        bit done = 1'b0;
        exp_t e;
        m0_addr = 14'h0060; m0_we = 2'b00;
        m0_req = 1'b1;
        while (!r_per_en && cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        chk_cnt++;
        if (!r_per_en)
            $display("FAIL mid_no_bus: per_en=%b want 1", r_per_en);
        else pass_cnt++;
        rst = 1'b1;
        m0_req = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (r_m0_ack !== 1'b0 || r_per_en !== 1'b0 || r_m0_dout !== 16'h0)
            $display("FAIL mid_no_ack: ack=%b en=%b dout=%h want 0",
                     r_m0_ack, r_per_en, r_m0_dout);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (r_m0_ack !== 1'b0 || r_per_en !== 1'b0)
            $display("FAIL mid_idle: ack=%b en=%b want 0",
                     r_m0_ack, r_per_en);
        else pass_cnt++;
        e.m = 1'b0; e.d = 16'h0060;
        sbq.push_back(e);
        m0_req = 1'b1;
        cyc = 0;
        while (!done && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (r_m0_ack) begin
                e = sbq.pop_front();
                done = 1'b1;
                m0_req = 1'b0;
                chk_cnt++;
                if (r_m0_dout !== e.d || cyc != 2)
                    $display("FAIL mid_retry: dout=%h cyc=%0d want %h/2",
                             r_m0_dout, cyc, e.d);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (!done)
            $display("FAIL mid_timeout: no ack after reset");
        else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_rr_contention();
        test_write_read();
        test_stream();
        test_fixed();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
